// File: rtl/alu_decode_if.sv
// Request/result bundle for alu_decode_stage: decode request fields in, ALU control code out.
// A transfer happens on a rising clock edge when valid & ready are both high; a producer holds
// valid and its payload stable until that edge, and ready may depend combinationally on the far side.
interface alu_decode_if #(
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         alu_op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               op_b5;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  alu_ctrl;
    logic               illegal;
    logic               busy;

    modport master (
        output in_valid, alu_op, funct3, funct7b5, op_b5, shamt, out_ready,
        input  in_ready, out_valid, alu_ctrl, illegal, busy
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7b5, op_b5, shamt, out_ready,
        output in_ready, out_valid, alu_ctrl, illegal, busy
    );
endinterface

// File: rtl/alu_decode_stage.sv
// ALU control decode stage with an IDLE/HOLD result buffer and optional multi-cycle shift timing.
// Define ALU_MULTICYCLE_SHIFT_EN to make shifts take ceil(shamt/SHIFT_STEP) cycles via a SHIFT state.
module alu_decode_stage #(
    parameter int CTRL_W     = 4,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_decode_if.slave bus,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

`ifdef ALU_MULTICYCLE_SHIFT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_t;
`endif

    state_t            state;
    logic [CTRL_W-1:0] ctrl_q;
    logic              illegal_q;
    logic              out_valid_q;
    logic [3:0]        dec_ctrl;
    logic              dec_illegal;
    logic              in_ready_c;
    logic              accept;

    always_comb begin
        dec_ctrl    = OP_ADD;
        dec_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: dec_ctrl = OP_ADD;
            2'b01: dec_ctrl = OP_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  dec_ctrl = (bus.funct7b5 & bus.op_b5) ? OP_SUB : OP_ADD;
                    3'b001:  dec_ctrl = OP_SLL;
                    3'b010:  dec_ctrl = OP_SLT;
                    3'b011:  dec_ctrl = OP_SLTU;
                    3'b100:  dec_ctrl = OP_XOR;
                    3'b101:  dec_ctrl = bus.funct7b5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_ctrl = OP_OR;
                    default: dec_ctrl = OP_AND;
                endcase
            end
            default: begin
                dec_ctrl    = OP_ADD;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Ready is held low during reset; in HOLD a new request may enter only as the result drains.
    assign in_ready_c = rst_n & ((state == IDLE) | ((state == HOLD) & bus.out_ready));
    assign accept     = bus.in_valid & in_ready_c;

`ifdef ALU_MULTICYCLE_SHIFT_EN
    localparam int CNT_W   = SHAMT_W + 1;
    localparam int STEP_LG = $clog2(SHIFT_STEP);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dec_cycles;
    logic             dec_shift;
    logic             busy_q;

    assign dec_shift  = (dec_ctrl == OP_SLL) | (dec_ctrl == OP_SRL) | (dec_ctrl == OP_SRA);
    assign dec_cycles = (CNT_W'(bus.shamt) + CNT_W'(SHIFT_STEP - 1)) >> STEP_LG;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            ctrl_q    <= CTRL_W'(dec_ctrl);
            illegal_q <= dec_illegal;
            if (dec_shift && (dec_cycles > CNT_W'(1))) begin
                state       <= SHIFT;
                cnt         <= dec_cycles - CNT_W'(1);
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                state       <= HOLD;
                cnt         <= '0;
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
            end
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == CNT_W'(1)) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
`else
    logic unused_shamt;
    assign unused_shamt = ^bus.shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state       <= HOLD;
            ctrl_q      <= CTRL_W'(dec_ctrl);
            illegal_q   <= dec_illegal;
            out_valid_q <= 1'b1;
        end else if ((state == HOLD) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.illegal   = illegal_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized and directed bench for alu_decode_stage against a transaction-level reference model.
module tb_alu_decode_stage;

  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 1;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  alu_decode_if #(.CTRL_W(CTRL_W), .SHAMT_W(SHAMT_W)) bus ();

  alu_decode_stage #(.CTRL_W(CTRL_W), .SHAMT_W(SHAMT_W), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int t     = 0;

  // scoreboard: at most one result in flight, {illegal, alu_ctrl}
  logic [4:0] exp_q[$];
  int         rdy_t    = 0;
  bit         accepted = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, t);
    end
  endtask

  // reference decode straight from the opcode table
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f7, input logic ob5);
    logic [3:0] code;
    logic       ill;
    ill = 1'b0;
    if (op == 2'b00)      code = 4'd0;
    else if (op == 2'b01) code = 4'd1;
    else if (op == 2'b11) begin code = 4'd0; ill = 1'b1; end
    else begin
      case (f3)
        3'd0: code = (f7 && ob5) ? 4'd1 : 4'd0;
        3'd1: code = 4'd7;
        3'd2: code = 4'd5;
        3'd3: code = 4'd6;
        3'd4: code = 4'd4;
        3'd5: code = f7 ? 4'd9 : 4'd8;
        3'd6: code = 4'd3;
        default: code = 4'd2;
      endcase
    end
    return {ill, code};
  endfunction

  function automatic int ref_latency(input logic [3:0] code, input int sh);
    int n;
    n = 1;
`ifdef ALU_MULTICYCLE_SHIFT_EN
    if (code == 4'd7 || code == 4'd8 || code == 4'd9) begin
      n = (sh + STEP - 1) / STEP;
      if (n < 1) n = 1;
    end
`else
    if (code == 4'd15 && sh < 0) n = 1;
`endif
    return n;
  endfunction

  // one clock: check outputs against the model, then let the edge happen
  task automatic cycle();
    bit         ov_e, bz_e, ir_e, acc, drn;
    logic [4:0] d;
    int         l;
    #1;
    ov_e = (exp_q.size() != 0) && (t >= rdy_t);
    bz_e = (exp_q.size() != 0) && (t < rdy_t);
    ir_e = (exp_q.size() == 0) || (ov_e && bus.out_ready);
    check("in_ready", 32'(bus.in_ready), 32'(ir_e));
    check("out_valid", 32'(bus.out_valid), 32'(ov_e));
    check("busy", 32'(bus.busy), 32'(bz_e));
    if (ov_e) begin
      check("alu_ctrl", 32'(bus.alu_ctrl), 32'(exp_q[0][3:0]));
      check("illegal", 32'(bus.illegal), 32'(exp_q[0][4]));
    end
    acc = bus.in_valid && ir_e;
    drn = ov_e && bus.out_ready;
    d   = ref_decode(bus.alu_op, bus.funct3, bus.funct7b5, bus.op_b5);
    l   = ref_latency(d[3:0], int'(bus.shamt));
    @(posedge clk);
    if (drn) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(d);
      rdy_t = t + l;
    end
    accepted = acc;
    t++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic ob5, input logic [SHAMT_W-1:0] sh);
    bus.alu_op    = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.op_b5     = ob5;
    bus.shamt     = sh;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    accepted = 0;
    for (int k = 0; k < 60 && !accepted; k++) cycle();
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cycle();
    if (exp_q.size() != 0) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct3    = 3'd0;
    bus.funct7b5  = 1'b0;
    bus.op_b5     = 1'b0;
    bus.shamt     = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // SUB vs ADD on funct3=000
    send(2'b10, 3'd0, 1'b1, 1'b1, 5'd0);
    send(2'b10, 3'd0, 1'b1, 1'b0, 5'd0);
    drain();
    // reserved class, load/store, branch
    send(2'b11, 3'd5, 1'b1, 1'b1, 5'd3);
    send(2'b00, 3'd7, 1'b0, 1'b0, 5'd0);
    send(2'b01, 3'd1, 1'b0, 1'b0, 5'd9);
    drain();
    // SRA by 5, then SLL by 31
    send(2'b10, 3'd5, 1'b1, 1'b0, 5'd5);
    drain();
    send(2'b10, 3'd1, 1'b0, 1'b1, 5'd31);
    drain();

    // stall in HOLD with a waiting request, then drain and accept together
    send(2'b10, 3'd4, 1'b0, 1'b1, 5'd0);
    bus.out_ready = 1'b0;
    cycle();
    bus.in_valid = 1'b1;
    bus.alu_op   = 2'b10;
    bus.funct3   = 3'd6;
    for (int k = 0; k < 3; k++) cycle();
    bus.out_ready = 1'b1;
    cycle();
    check("b2b_accept", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
    cycle();
    drain();

    // reset in the middle of a long shift, then a plain ADD
    send(2'b10, 3'd5, 1'b0, 1'b0, 5'd20);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    do_reset();
    send(2'b00, 3'd0, 1'b0, 1'b0, 5'd0);
    drain();

    // random traffic with inputs wiggling while a result is pending
    for (int k = 0; k < 600; k++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.alu_op    = 2'($urandom_range(0, 3));
      bus.funct3    = 3'($urandom_range(0, 7));
      bus.funct7b5  = 1'($urandom_range(0, 1));
      bus.op_b5     = 1'($urandom_range(0, 1));
      bus.shamt     = ($urandom_range(0, 3) == 0) ? SHAMT_W'($urandom_range(0, 31))
                                                  : SHAMT_W'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of alu_ctrl (legal values >= 4, upper bits zero).
REQ-002 SHALL have parameter SHAMT_W, default 5, width of shamt.
REQ-003 SHALL have parameter SHIFT_STEP, default 1, bits shifted per cycle (power of two, 1..2**SHAMT_W).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-008 SHALL have port alu_op  input  2  main-decoder class: 00 load/store, 01 branch, 10 R/I-type, 11 reserved.
REQ-009 SHALL have port funct3  input  3  instruction funct3.
REQ-010 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-011 SHALL have port op_b5  input  1  opcode bit 5 (1 = R-type).
REQ-012 SHALL have port shamt  input  SHAMT_W  shift amount.
REQ-013 SHALL have port out_valid  output  1  alu_ctrl/illegal valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port alu_ctrl  output  CTRL_W  ALU operation code.
REQ-016 SHALL have port illegal  output  1  reserved encoding flag, valid with out_valid.
REQ-017 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-018 Codes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
REQ-019 alu_op 00 SHALL decode ADD; 01 SHALL decode SUB; 11 SHALL decode ADD with illegal=1.
REQ-020 alu_op 10 SHALL decode by funct3: 000 SUB if funct7b5&op_b5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7b5 else SRL; 110 OR; 111 AND.
REQ-021 FSM states SHALL be IDLE, SHIFT, HOLD.
REQ-022 IDLE: in_ready=1, out_valid=0; accepted non-shift op, or shift with cycles N=ceil(shamt/SHIFT_STEP) <= 1, SHALL go to HOLD next cycle (latency 1).
REQ-023 Accepted shift op (SLL/SRL/SRA) with N > 1 SHALL load counter N-1, go to SHIFT, and decrement each cycle; at counter 1 go to HOLD, giving latency N.
REQ-024 HOLD: out_valid=1; alu_ctrl/illegal SHALL stay stable until out_valid & out_ready.
REQ-025 HOLD: in_ready SHALL equal out_ready; simultaneous drain and accept SHALL load the new request with no bubble (back-to-back throughput 1 for latency-1 ops).
REQ-026 HOLD with out_ready=1 and no accept SHALL return to IDLE.
REQ-027 SHIFT: in_ready=0, out_valid=0, busy=1; inputs ignored.
REQ-028 Request fields SHALL be captured on accept; later input changes SHALL not affect the result.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, alu_ctrl 0, illegal 0, out_valid 0, busy 0, in_ready 0 while asserted.
REQ-030 Reset during SHIFT or HOLD SHALL discard the pending result; first accept after release behaves as from IDLE.

Configuration
REQ-031 With macro ALU_MULTICYCLE_SHIFT_EN defined, shifts SHALL use SHIFT state per REQ-023.
REQ-032 Without ALU_MULTICYCLE_SHIFT_EN, all ops SHALL have latency 1, shamt SHALL be ignored, SHIFT state and counter SHALL be absent, busy SHALL be tied 0.

Verification
REQ-033 alu_op=10, funct3=000, funct7b5=1, op_b5=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=1 (SUB); op_b5=0 -> alu_ctrl=0.
REQ-034 Macro defined, SHIFT_STEP=1, funct3=101, funct7b5=1, shamt=5 -> busy high 4 cycles, out_valid on cycle 5, alu_ctrl=9.
REQ-035 alu_op=11 -> alu_ctrl=0, illegal=1 with out_valid.
REQ-036 out_ready=0 for 3 cycles in HOLD, in_valid=1 -> in_ready=0, alu_ctrl stable; out_ready=1 -> drain and accept same cycle, next result following cycle.
REQ-037 rst_n low mid-SHIFT (shamt=20) -> out_valid=0, busy=0 immediately; after release, ADD request completes in 1 cycle.
REQ-038 Macro undefined, SLL with shamt=31 -> alu_ctrl=7 after 1 cycle, busy never high.
